// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv datapath: shift mode encodings and
// the helper that turns shift-amount width into a register-stage count.
package multdiv_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_e;

    // Number of register stages needed when each stage holds lvls_per_reg
    // mux levels and there is one mux level per shift-amount bit.
    function automatic int num_stages(input int shamt_w, input int lvls_per_reg);
        return (shamt_w + lvls_per_reg - 32'sd1) / lvls_per_reg;
    endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// One combinational mux level of the barrel shifter: optionally shifts
// right by AMOUNT, filling from the fill bit or rotating the low bits in.
module shift_pipe_level #(
    parameter int WIDTH  = 66,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    input  logic             fill,
    input  logic             rot,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted_s;

    if (AMOUNT < WIDTH) begin : g_shift
        // Right shift by AMOUNT, either rotating or filling the vacated MSBs
        always_comb begin
            if (rot) begin
                shifted_s = {data[AMOUNT-1:0], data[WIDTH-1:AMOUNT]};
            end else begin
                shifted_s = {{AMOUNT{fill}}, data[WIDTH-1:AMOUNT]};
            end
        end
    end else begin : g_wide
        // A shift at least as wide as the word leaves only fill bits
        always_comb begin
            if (rot) begin
                shifted_s = data;
            end else begin
                shifted_s = {WIDTH{fill}};
            end
        end
    end

    // Apply this level only when its shift-amount bit is set
    always_comb begin
        if (sel) begin
            result = shifted_s;
        end else begin
            result = data;
        end
    end

endmodule

// File: rtl/shift_pipe_multdiv.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with a valid/ready handshake
// on both sides and a bubble-collapsing ready chain. One mux level per
// shift-amount bit, LVLS_PER_REG levels between register stages.
module shift_pipe_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH        = 66,
    parameter int SHAMT_W      = 7,
    parameter int LVLS_PER_REG = 2,
    parameter int TAG_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_ovf
);

    localparam int L = num_stages(SHAMT_W, LVLS_PER_REG);

    // Mirror a word end-for-end; SLL is done as a right shift between two of these
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // Stage registers
    logic [L-1:0]       v_r;
    logic [WIDTH-1:0]   data_r  [L];
    logic [SHAMT_W-1:0] shamt_r [L];
    logic [1:0]         mode_r  [L];
    logic [TAG_W-1:0]   tag_r   [L];
    logic [L-1:0]       ovf_r;
    logic               sign_r  [L];

    // Handshake
    logic [L:0]         ready_s;
    logic [L-1:0]       load_s;
    logic               in_ready_s;
    logic               in_ovf_s;

    // What each stage sees at its input (the pipe input for stage 0)
    logic [WIDTH-1:0]   src_data_s  [L];
    logic [SHAMT_W-1:0] src_shamt_s [L];
    logic [1:0]         src_mode_s  [L];
    logic [TAG_W-1:0]   src_tag_s   [L];
    logic [L-1:0]       src_ovf_s;
    logic               src_sign_s  [L];
    logic [L-1:0]       src_fill_s;
    logic [L-1:0]       src_rot_s;

    // Stage results
    logic [WIDTH-1:0]   res_data_s  [L];
    logic [WIDTH-1:0]   next_data_s [L];
    logic [WIDTH-1:0]   post_data_s;

    // Ready chain from the output back to the input; a stage can take an item
    // when it is empty or its occupant moves on this cycle
    always_comb begin
        ready_s    = {(L+1){1'b0}};
        load_s     = {L{1'b0}};
        ready_s[L] = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            ready_s[k] = ~v_r[k] | ready_s[k+1];
        end
        in_ready_s = ready_s[0] & ~reset & ~flush;
        load_s[0]  = in_valid & in_ready_s;
        for (int k = 1; k < L; k++) begin
            load_s[k] = v_r[k-1] & ready_s[k];
        end
    end

    // Stage-input selection; overflow and sign are resolved once at the input.
    // An overflowing item travels with a zero shift so ROR returns it untouched.
    always_comb begin
        in_ovf_s       = (32'(in_shamt) >= WIDTH);
        src_data_s[0]  = (in_mode == MODE_SLL) ? bit_rev(in_data) : in_data;
        src_shamt_s[0] = in_ovf_s ? {SHAMT_W{1'b0}} : in_shamt;
        src_mode_s[0]  = in_mode;
        src_tag_s[0]   = in_tag;
        src_ovf_s[0]   = in_ovf_s;
        src_sign_s[0]  = in_data[WIDTH-1];
        for (int k = 1; k < L; k++) begin
            src_data_s[k]  = data_r[k-1];
            src_shamt_s[k] = shamt_r[k-1];
            src_mode_s[k]  = mode_r[k-1];
            src_tag_s[k]   = tag_r[k-1];
            src_ovf_s[k]   = ovf_r[k-1];
            src_sign_s[k]  = sign_r[k-1];
        end
        for (int k = 0; k < L; k++) begin
            src_fill_s[k] = (src_mode_s[k] == MODE_SRA) & src_sign_s[k];
            src_rot_s[k]  = (src_mode_s[k] == MODE_ROR);
        end
    end

    // Mux levels, ascending, LVLS_PER_REG of them feeding each register stage
    for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
        localparam int STG = j / LVLS_PER_REG;
        logic [WIDTH-1:0] lin_s;
        logic [WIDTH-1:0] lout_s;

        if (j % LVLS_PER_REG == 0) begin : g_head
            assign lin_s = src_data_s[STG];
        end else begin : g_link
            assign lin_s = g_lvl[j-1].lout_s;
        end

        shift_pipe_level #(
            .WIDTH  (WIDTH),
            .AMOUNT (32'd1 << j)
        ) u_level (
            .data   (lin_s),
            .sel    (src_shamt_s[STG][j]),
            .fill   (src_fill_s[STG]),
            .rot    (src_rot_s[STG]),
            .result (lout_s)
        );
    end

    // Last mux level of each stage is that stage's result
    for (genvar k = 0; k < L; k++) begin : g_res
        localparam int LAST = ((k + 1) * LVLS_PER_REG < SHAMT_W)
                            ? ((k + 1) * LVLS_PER_REG - 1) : (SHAMT_W - 1);
        assign res_data_s[k] = g_lvl[LAST].lout_s;
    end

    // Final stage: undo the SLL mirroring and apply the overflow results
    always_comb begin
        post_data_s = res_data_s[L-1];
        case (src_mode_s[L-1])
            MODE_SLL: post_data_s = src_ovf_s[L-1] ? {WIDTH{1'b0}} : bit_rev(res_data_s[L-1]);
            MODE_SRL: post_data_s = src_ovf_s[L-1] ? {WIDTH{1'b0}} : res_data_s[L-1];
            MODE_SRA: post_data_s = src_ovf_s[L-1] ? {WIDTH{src_sign_s[L-1]}} : res_data_s[L-1];
            MODE_ROR: post_data_s = res_data_s[L-1];
            default:  post_data_s = res_data_s[L-1];
        endcase
        for (int k = 0; k < L; k++) begin
            next_data_s[k] = res_data_s[k];
        end
        next_data_s[L-1] = post_data_s;
    end

    // Pipeline registers: valid bits track occupancy, payload moves only on a load
    always_ff @(posedge clock) begin
        if (reset) begin
            v_r   <= {L{1'b0}};
            ovf_r <= {L{1'b0}};
            for (int k = 0; k < L; k++) begin
                data_r[k]  <= {WIDTH{1'b0}};
                shamt_r[k] <= {SHAMT_W{1'b0}};
                mode_r[k]  <= 2'b00;
                tag_r[k]   <= {TAG_W{1'b0}};
                sign_r[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (flush) begin
                    v_r[k] <= 1'b0;
                end else begin
                    v_r[k] <= load_s[k] | (v_r[k] & ~ready_s[k+1]);
                end
                if (load_s[k]) begin
                    data_r[k]  <= next_data_s[k];
                    shamt_r[k] <= src_shamt_s[k];
                    mode_r[k]  <= src_mode_s[k];
                    tag_r[k]   <= src_tag_s[k];
                    ovf_r[k]   <= src_ovf_s[k];
                    sign_r[k]  <= src_sign_s[k];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_r[L-1];
    assign out_data  = data_r[L-1];
    assign out_tag   = tag_r[L-1];
    assign out_ovf   = ovf_r[L-1];

endmodule

// File: tb/tb_shift_pipe_multdiv.sv
// Scoreboard bench for shift_pipe_multdiv: the driver pushes hand-computed
// expectations when an item is accepted, the monitor pops and compares on
// every output transfer.
module tb_shift_pipe_multdiv;
    import multdiv_pkg::*;

    localparam int WIDTH   = 66;
    localparam int SHAMT_W = 7;
    localparam int TAG_W   = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_ovf;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt = 0;

    // Back-pressure vectors, tags 0..5
    logic [WIDTH-1:0]   bp_data [6] = '{66'h0_0000_0000_0000_00F0, 66'h0_0000_0000_0000_0001,
                                        66'h0_0000_0000_0000_0003, 66'h3_FFFF_FFFF_FFFF_FF00,
                                        66'h2_0000_0000_0000_0000, 66'h2_0000_0000_0000_0001};
    logic [SHAMT_W-1:0] bp_sh   [6] = '{7'd4, 7'd8, 7'd1, 7'd8, 7'd65, 7'd0};
    logic [1:0]         bp_mode [6] = '{MODE_SRL, MODE_SLL, MODE_ROR, MODE_SRA, MODE_SRL, MODE_SRA};
    logic [WIDTH-1:0]   bp_exp  [6] = '{66'h0_0000_0000_0000_000F, 66'h0_0000_0000_0000_0100,
                                        66'h2_0000_0000_0000_0001, 66'h3_FFFF_FFFF_FFFF_FFFF,
                                        66'h0_0000_0000_0000_0001, 66'h2_0000_0000_0000_0001};

    shift_pipe_multdiv #(
        .WIDTH        (WIDTH),
        .SHAMT_W      (SHAMT_W),
        .LVLS_PER_REG (2),
        .TAG_W        (TAG_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Offer one item (called just after a rising edge); record the expectation on accept
    task automatic offer(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh,
                         input logic [1:0] m, input logic [TAG_W-1:0] t,
                         input logic [WIDTH-1:0] ed, input logic eovf, input bit push);
        int waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_mode  = m;
        in_tag   = t;
        @(negedge clock);
        if (!in_ready) stall_cnt++;
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'(in_ready), 128'(1'b1));
        end else if (push) begin
            e.data = ed;
            e.tag  = t;
            e.ovf  = eovf;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for every expected result to be consumed
    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clock);
            c++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare each output transfer against the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got tag %0d data %h, required no output", out_tag, out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 128'(out_data), 128'(e.data));
                check("out_tag",  128'(out_tag),  128'(e.tag));
                check("out_ovf",  128'(out_ovf),  128'(e.ovf));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int tg;
        int vcnt;
        int first;
        int last;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = 2'b00; in_tag = '0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_in_ready",  128'(in_ready),  128'(1'b0));
        check("reset_out_valid", 128'(out_valid), 128'(1'b0));
        check("reset_out_data",  128'(out_data),  128'(0));
        check("reset_out_tag",   128'(out_tag),   128'(0));
        check("reset_out_ovf",   128'(out_ovf),   128'(1'b0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clock);
        #1;

        // 1: SRA with latency measurement
        offer(66'h2_0000_0000_0000_0000, 7'd4, MODE_SRA, 4'd3, 66'h3_E000_0000_0000_0000, 1'b0, 1'b1);
        early = 0;
        repeat (3) begin
            @(negedge clock);
            if (out_valid) early++;
        end
        check("latency_early", 128'(early), 128'(0));
        @(negedge clock);
        check("latency_valid", 128'(out_valid), 128'(1'b1));
        drain();

        // 2: basic modes
        offer(66'h1, 7'd65, MODE_SLL, 4'd1, 66'h2_0000_0000_0000_0000, 1'b0, 1'b1);
        offer(66'h1, 7'd1,  MODE_ROR, 4'd2, 66'h2_0000_0000_0000_0000, 1'b0, 1'b1);
        offer(66'h3, 7'd1,  MODE_SRL, 4'd4, 66'h1, 1'b0, 1'b1);
        drain();

        // 3: overflow
        offer(66'h3_FFFF_FFFF_FFFF_FFFF, 7'd70, MODE_SRL, 4'd5, 66'h0, 1'b1, 1'b1);
        offer(66'h3_FFFF_FFFF_FFFF_FFFF, 7'd70, MODE_SRA, 4'd6, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        offer(66'h3_FFFF_FFFF_FFFF_FFFF, 7'd70, MODE_ROR, 4'd7, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        offer(66'h1_2345_6789_ABCD_EF01, 7'd0,  MODE_SLL, 4'd8, 66'h1_2345_6789_ABCD_EF01, 1'b0, 1'b1);
        drain();

        // 4: back-pressure
        out_ready = 1'b0;
        tg = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (tg < 6);
            in_data  = bp_data[tg % 6];
            in_shamt = bp_sh[tg % 6];
            in_mode  = bp_mode[tg % 6];
            in_tag   = 4'(tg);
            @(negedge clock);
            if (in_valid && in_ready) begin
                exp_q.push_back('{data: bp_exp[tg], tag: 4'(tg), ovf: 1'b0});
                tg++;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 128'(tg), 128'(4));
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("bp_in_ready",  128'(in_ready),  128'(1'b0));
            check("bp_out_valid", 128'(out_valid), 128'(1'b1));
            check("bp_hold_data", 128'(out_data),  128'(bp_exp[0]));
            check("bp_hold_tag",  128'(out_tag),   128'(0));
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        offer(bp_data[4], bp_sh[4], bp_mode[4], 4'd4, bp_exp[4], 1'b0, 1'b1);
        offer(bp_data[5], bp_sh[5], bp_mode[5], 4'd5, bp_exp[5], 1'b0, 1'b1);
        drain();

        // 5: throughput, 8 back-to-back items
        stall_cnt = 0;
        vcnt = 0; first = -1; last = -1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    offer(66'h1, 7'(k), MODE_SLL, 4'(k), 66'h1 << k, 1'b0, 1'b1);
                end
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clock);
                    if (out_valid) begin
                        if (first < 0) first = c;
                        last = c;
                        vcnt++;
                    end
                end
            end
        join
        check("tp_stalls",   128'(stall_cnt), 128'(0));
        check("tp_valid_n",  128'(vcnt), 128'(8));
        check("tp_contig",   128'(last - first + 1), 128'(8));
        drain();

        // 6a: flush with 3 items in flight and one offered
        for (int k = 0; k < 3; k++) begin
            offer(66'hF, 7'd1, MODE_SRL, 4'(9 + k), 66'h7, 1'b0, 1'b0);
        end
        in_valid = 1'b1; in_data = 66'h5; in_shamt = 7'd0; in_mode = MODE_SRL; in_tag = 4'd12;
        flush = 1'b1;
        @(negedge clock);
        check("flush_in_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clock);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("flush_ready_after", 128'(in_ready), 128'(1'b1));
        vcnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) vcnt++;
        end
        check("flush_no_output", 128'(vcnt), 128'(0));
        @(posedge clock);
        #1;

        // 6b: same with reset
        for (int k = 0; k < 3; k++) begin
            offer(66'hF, 7'd1, MODE_SRL, 4'(13 + k), 66'h7, 1'b0, 1'b0);
        end
        in_valid = 1'b1; in_data = 66'h5; in_tag = 4'd1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clock);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_tag",  128'(out_tag),  128'(0));
        check("rst_out_ovf",  128'(out_ovf),  128'(1'b0));
        vcnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) vcnt++;
        end
        check("rst_no_output", 128'(vcnt), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
